// File: rtl/at_query_sched_if.sv
// UART-side link of the AT query scheduler: TX byte request path and RX byte/window path.
interface at_query_sched_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] data_Byte;
    logic       Rx_done;
    logic       rx_en;

    modport master (output tx_data, tx_start, rx_en, input tx_busy, data_Byte, Rx_done);
    modport slave  (input tx_data, tx_start, rx_en, output tx_busy, data_Byte, Rx_done);
endinterface

// File: rtl/at_query_sched.sv
// Periodic AT query controller: sends HEART/TEMP commands byte by byte, then waits for a
// "+...\r" reply with timeout and bounded retry, reporting per-query success and failure.
module at_query_sched #(
    parameter int unsigned POLL_CYCLES  = 50_000_000,
    parameter int unsigned RESP_TIMEOUT = 5_000_000,
    parameter int unsigned MAX_RETRY    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    at_query_sched_if.master uart,
    output logic             query_id,
    output logic             resp_ok,
    output logic             resp_timeout,
    output logic             hr_fail,
    output logic             temp_fail,
    output logic             busy
);
    localparam int unsigned PW = (POLL_CYCLES  > 1) ? $clog2(POLL_CYCLES)  : 1;
    localparam int unsigned TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam int unsigned RW = (MAX_RETRY    > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_TXWAIT, S_WAIT_RESP, S_DONE_OK, S_TIMEOUT
    } state_t;

    state_t        state;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] resp_cnt;
    logic [RW-1:0] retry_cnt;
    logic [3:0]    idx;
    logic [3:0]    last_idx;
    logic          plus_seen;
    logic          busy_seen;

    // Command ROM: 0 = "AT+HEART?\r\n", 1 = "AT+TEMP?\r\n"
    function automatic logic [7:0] cmd_byte(input logic qid, input logic [3:0] i);
        logic [7:0] b;
        b = 8'h00;
        if (!qid) begin
            case (i)
                4'd0: b = 8'h41;  4'd1: b = 8'h54;  4'd2:  b = 8'h2B;  4'd3: b = 8'h48;
                4'd4: b = 8'h45;  4'd5: b = 8'h41;  4'd6:  b = 8'h52;  4'd7: b = 8'h54;
                4'd8: b = 8'h3F;  4'd9: b = 8'h0D;  4'd10: b = 8'h0A;
                default: b = 8'h00;
            endcase
        end else begin
            case (i)
                4'd0: b = 8'h41;  4'd1: b = 8'h54;  4'd2: b = 8'h2B;  4'd3: b = 8'h54;
                4'd4: b = 8'h45;  4'd5: b = 8'h4D;  4'd6: b = 8'h50;  4'd7: b = 8'h3F;
                4'd8: b = 8'h0D;  4'd9: b = 8'h0A;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    assign last_idx = query_id ? 4'd9 : 4'd10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            poll_cnt      <= '0;
            resp_cnt      <= '0;
            retry_cnt     <= '0;
            idx           <= '0;
            plus_seen     <= 1'b0;
            busy_seen     <= 1'b0;
            query_id      <= 1'b0;
            resp_ok       <= 1'b0;
            resp_timeout  <= 1'b0;
            hr_fail       <= 1'b0;
            temp_fail     <= 1'b0;
            busy          <= 1'b0;
            uart.tx_data  <= 8'h00;
            uart.tx_start <= 1'b0;
            uart.rx_en    <= 1'b0;
        end else begin
            uart.tx_start <= 1'b0;
            resp_ok       <= 1'b0;
            resp_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (poll_cnt == POLL_LAST) begin
                        if (en) begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end
                    end else begin
                        poll_cnt <= poll_cnt + PW'(1);
                    end
                end
                S_LOAD: begin
                    idx   <= '0;
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (!uart.tx_busy) begin
                        uart.tx_data  <= cmd_byte(query_id, idx);
                        uart.tx_start <= 1'b1;
                        busy_seen     <= 1'b0;
                        state         <= S_TXWAIT;
                    end
                end
                // A byte is finished once the transmitter has gone busy and then idle again
                S_TXWAIT: begin
                    if (uart.tx_busy) begin
                        busy_seen <= 1'b1;
                    end else if (busy_seen) begin
                        if (idx == last_idx) begin
                            resp_cnt   <= '0;
                            plus_seen  <= 1'b0;
                            uart.rx_en <= 1'b1;
                            state      <= S_WAIT_RESP;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= S_SEND;
                        end
                    end
                end
                // A completing CR takes priority over timeout expiry in the same cycle
                S_WAIT_RESP: begin
                    if (uart.Rx_done && (uart.data_Byte == 8'h0D) && plus_seen) begin
                        resp_ok    <= 1'b1;
                        uart.rx_en <= 1'b0;
                        state      <= S_DONE_OK;
                    end else if (resp_cnt == RESP_LAST) begin
                        resp_timeout <= (retry_cnt >= RETRY_MAX);
                        uart.rx_en   <= 1'b0;
                        state        <= S_TIMEOUT;
                    end else begin
                        resp_cnt <= resp_cnt + TW'(1);
                    end
                    if (uart.Rx_done && (uart.data_Byte == 8'h2B)) begin
                        plus_seen <= 1'b1;
                    end
                end
                S_DONE_OK: begin
                    if (query_id) temp_fail <= 1'b0;
                    else          hr_fail   <= 1'b0;
                    retry_cnt <= '0;
                    query_id  <= ~query_id;
                    poll_cnt  <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                S_TIMEOUT: begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        state     <= S_LOAD;
                    end else begin
                        if (query_id) temp_fail <= 1'b1;
                        else          hr_fail   <= 1'b1;
                        retry_cnt <= '0;
                        query_id  <= ~query_id;
                        poll_cnt  <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_at_query_sched.sv
// Directed bench for at_query_sched with a 10-cycle UART TX busy model and injected replies.
`timescale 1ns/1ps
module tb_at_query_sched;
    localparam int unsigned P  = 100;
    localparam int unsigned RT = 200;
    localparam int unsigned MR = 1;
    localparam logic [7:0] HEART_CMD [11] = '{8'h41, 8'h54, 8'h2B, 8'h48, 8'h45, 8'h41,
                                              8'h52, 8'h54, 8'h3F, 8'h0D, 8'h0A};
    localparam logic [7:0] TEMP_CMD [10]  = '{8'h41, 8'h54, 8'h2B, 8'h54, 8'h45, 8'h4D,
                                              8'h50, 8'h3F, 8'h0D, 8'h0A};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic query_id, resp_ok, resp_timeout, hr_fail, temp_fail, busy;

    at_query_sched_if uart_if ();

    at_query_sched #(.POLL_CYCLES(P), .RESP_TIMEOUT(RT), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .uart(uart_if),
        .query_id(query_id), .resp_ok(resp_ok), .resp_timeout(resp_timeout),
        .hr_fail(hr_fail), .temp_fail(temp_fail), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int overlap_cnt = 0;
    logic [7:0] got [16];
    int got_n;
    int first_tx_cyc;
    int rel_cyc;
    int ok_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // UART TX model: busy for 10 cycles starting the cycle after tx_start
    always @(posedge clk) begin
        if (uart_if.tx_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_if.tx_busy = (busy_cnt != 0);

    always @(negedge clk) if (uart_if.tx_start && uart_if.tx_busy) overlap_cnt <= overlap_cnt + 1;

    task automatic wait_tx(input int n, input int budget, output bit ok);
        int t = 0;
        ok = 1'b1;
        got_n = 0;
        while (got_n < n) begin
            @(negedge clk);
            if (uart_if.tx_start) begin
                got[got_n] = uart_if.tx_data;
                if (got_n == 0) first_tx_cyc = cyc;
                got_n++;
            end
            t++;
            if (t > budget) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    // which: 0 = rx_en, 1 = resp_ok, 2 = resp_timeout; returns at the negedge where it is high
    task automatic wait_sig(input int which, input int budget, output bit ok);
        logic s;
        ok = 1'b0;
        for (int t = 0; t <= budget; t++) begin
            case (which)
                0: s = uart_if.rx_en;
                1: s = resp_ok;
                default: s = resp_timeout;
            endcase
            if (s === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_if.data_Byte = b;
        uart_if.Rx_done   = 1'b1;
        @(negedge clk);
        uart_if.Rx_done   = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({uart_if.tx_start, uart_if.tx_data, uart_if.rx_en, query_id, resp_ok, resp_timeout,
             hr_fail, temp_fail, busy} !== 16'h0) begin
            fails++; $display("FAIL reset_outputs: got tx_data=%h busy=%b qid=%b, need all 0",
                              uart_if.tx_data, busy, query_id);
        end
        rst_n = 1'b1;
        rel_cyc = cyc;
        repeat (50) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL idle_before_poll: busy=%b need 0", busy); end
    endtask

    task automatic test_normal_heart();
        bit ok;
        wait_tx(11, 2000, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL heart_tx_count: got %0d bytes need 11", got_n); end
        tests++;
        if (first_tx_cyc - rel_cyc < P || first_tx_cyc - rel_cyc > P + 5) begin
            fails++; $display("FAIL first_tx_delay: got %0d need %0d..%0d", first_tx_cyc - rel_cyc, P, P + 5);
        end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (got[i] !== HEART_CMD[i]) begin
                fails++; $display("FAIL heart_byte[%0d]: got %h need %h", i, got[i], HEART_CMD[i]);
            end
        end
        wait_sig(0, 100, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL heart_rx_en: got 0 need 1"); end
        send_str("+HEART=72");
        send_byte(8'h0D);
        wait_sig(1, 10, ok);
        ok_cyc = cyc;
        tests++;
        if (!ok || query_id !== 1'b0) begin
            fails++; $display("FAIL heart_resp_ok: ok=%b qid=%b need ok=1 qid=0", ok, query_id);
        end
        @(negedge clk);
        tests++;
        if ({resp_ok, query_id, hr_fail} !== 3'b010) begin
            fails++; $display("FAIL heart_after: got ok,qid,hr=%b need 010", {resp_ok, query_id, hr_fail});
        end
    endtask

    task automatic test_alternation();
        bit ok;
        wait_tx(10, 2000, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL temp_tx_count: got %0d bytes need 10", got_n); end
        tests++;
        if (first_tx_cyc - ok_cyc < P || first_tx_cyc - ok_cyc > P + 5) begin
            fails++; $display("FAIL poll_gap: got %0d need %0d..%0d", first_tx_cyc - ok_cyc, P, P + 5);
        end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (got[i] !== TEMP_CMD[i]) begin
                fails++; $display("FAIL temp_byte[%0d]: got %h need %h", i, got[i], TEMP_CMD[i]);
            end
        end
        wait_sig(0, 100, ok);
        send_str("+T=36.50");
        send_byte(8'h0D);
        wait_sig(1, 10, ok);
        ok_cyc = cyc;
        tests++;
        if (!ok || query_id !== 1'b1) begin
            fails++; $display("FAIL temp_resp_ok: ok=%b qid=%b need ok=1 qid=1", ok, query_id);
        end
        @(negedge clk);
        tests++;
        if ({query_id, temp_fail} !== 2'b00) begin
            fails++; $display("FAIL temp_after: got qid,tf=%b need 00", {query_id, temp_fail});
        end
    endtask

    task automatic test_retry_fail();
        bit ok;
        int win;
        for (int attempt = 0; attempt < 2; attempt++) begin
            wait_tx(11, 2000, ok);
            tests++;
            if (!ok || got[3] !== 8'h48) begin
                fails++; $display("FAIL retry_send%0d: ok=%b byte3=%h need 48", attempt, ok, got[3]);
            end
            wait_sig(0, 100, ok);
            win = 0;
            while (uart_if.rx_en === 1'b1 && win < 1000) begin
                win++;
                @(negedge clk);
            end
            tests++;
            if (win != RT) begin fails++; $display("FAIL retry_window%0d: got %0d need %0d", attempt, win, RT); end
            tests++;
            if (resp_timeout !== (attempt == 1)) begin
                fails++; $display("FAIL retry_pulse%0d: got %b need %b", attempt, resp_timeout, attempt == 1);
            end
        end
        tests++;
        if (query_id !== 1'b0) begin fails++; $display("FAIL timeout_qid: got %b need 0", query_id); end
        @(negedge clk);
        tests++;
        if ({resp_timeout, hr_fail, query_id} !== 3'b011) begin
            fails++; $display("FAIL timeout_after: got to,hr,qid=%b need 011", {resp_timeout, hr_fail, query_id});
        end
        wait_tx(10, 2000, ok);
        tests++;
        if (!ok || got[3] !== 8'h54) begin fails++; $display("FAIL next_is_temp: byte3=%h need 54", got[3]); end
        wait_sig(0, 100, ok);
        send_str("+T=1");
        send_byte(8'h0D);
        wait_sig(1, 10, ok);
        @(negedge clk);
    endtask

    task automatic test_echo_recovery();
        bit ok;
        int seen = 0;
        wait_tx(11, 2000, ok);
        wait_sig(0, 100, ok);
        tests++;
        if (!ok || hr_fail !== 1'b1) begin fails++; $display("FAIL echo_pre: rx_en ok=%b hr=%b need 1,1", ok, hr_fail); end
        send_byte(8'h0D);
        for (int i = 0; i < 5; i++) begin
            if (resp_ok === 1'b1) seen++;
            @(negedge clk);
        end
        tests++;
        if (seen != 0 || uart_if.rx_en !== 1'b1) begin
            fails++; $display("FAIL echo_ignored: resp_ok seen %0d rx_en=%b need 0,1", seen, uart_if.rx_en);
        end
        send_str("+HEART=N");
        send_byte(8'h0D);
        wait_sig(1, 10, ok);
        tests++;
        if (!ok || query_id !== 1'b0) begin fails++; $display("FAIL echo_resp_ok: ok=%b qid=%b need 1,0", ok, query_id); end
        @(negedge clk);
        tests++;
        if (hr_fail !== 1'b0) begin fails++; $display("FAIL hr_fail_clear: got %b need 0", hr_fail); end
    endtask

    task automatic test_boundary_en();
        bit ok;
        int n_tx = 0;
        int en_cyc;
        en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (uart_if.tx_start) n_tx++;
        end
        tests++;
        if (n_tx != 0 || busy !== 1'b0) begin fails++; $display("FAIL en_low_hold: tx=%0d busy=%b need 0,0", n_tx, busy); end
        en = 1'b1;
        en_cyc = cyc;
        wait_tx(1, 10, ok);
        tests++;
        if (!ok || first_tx_cyc - en_cyc > 4 || got[0] !== 8'h41) begin
            fails++; $display("FAIL en_rise_start: ok=%b lat=%0d byte=%h need 1,<=4,41", ok, first_tx_cyc - en_cyc, got[0]);
        end
        wait_tx(9, 2000, ok);
        wait_sig(0, 100, ok);
        send_str("+T=2");
        send_byte(8'h0D);
        wait_sig(1, 10, ok);
        @(negedge clk);
    endtask

    task automatic test_coincident();
        bit ok;
        int k;
        int n_tx = 0;
        wait_tx(11, 2000, ok);
        wait_sig(0, 100, ok);
        k = 1;
        while (k < RT) begin
            if (k == 3) begin uart_if.data_Byte = 8'h2B; uart_if.Rx_done = 1'b1; end
            else uart_if.Rx_done = 1'b0;
            @(negedge clk);
            k++;
        end
        uart_if.data_Byte = 8'h0D;
        uart_if.Rx_done   = 1'b1;
        @(negedge clk);
        uart_if.Rx_done   = 1'b0;
        tests++;
        if ({resp_ok, resp_timeout, uart_if.rx_en, query_id} !== 4'b1000) begin
            fails++; $display("FAIL cr_vs_timeout: got ok,to,rx_en,qid=%b need 1000",
                              {resp_ok, resp_timeout, uart_if.rx_en, query_id});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_if.tx_start) n_tx++;
        end
        tests++;
        if (n_tx != 0 || query_id !== 1'b1) begin
            fails++; $display("FAIL no_retry_after_ok: tx=%0d qid=%b need 0,1", n_tx, query_id);
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        wait_tx(4, 2000, ok);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({uart_if.tx_start, uart_if.tx_data, uart_if.rx_en, query_id, resp_ok, resp_timeout,
             hr_fail, temp_fail, busy} !== 16'h0) begin
            fails++; $display("FAIL mid_reset_outputs: tx_start=%b tx_data=%h busy=%b need 0",
                              uart_if.tx_start, uart_if.tx_data, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_tx(2, 400, ok);
        tests++;
        if (!ok || first_tx_cyc - rel_cyc < P || got[0] !== 8'h41 || got[1] !== 8'h54) begin
            fails++; $display("FAIL restart_after_reset: ok=%b gap=%0d bytes=%h %h need 1,>=%0d,41 54",
                              ok, first_tx_cyc - rel_cyc, got[0], got[1], P);
        end
        tests++;
        if (query_id !== 1'b0) begin fails++; $display("FAIL restart_qid: got %b need 0", query_id); end
        tests++;
        if (overlap_cnt != 0) begin fails++; $display("FAIL start_while_busy: got %0d need 0", overlap_cnt); end
    endtask

    initial begin
        uart_if.data_Byte = 8'h00;
        uart_if.Rx_done   = 1'b0;
        test_reset();
        test_normal_heart();
        test_alternation();
        test_retry_fail();
        test_echo_recovery();
        test_boundary_en();
        test_coincident();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
